// File: rtl/mult_pkg.sv
// Shared types for the RV32M multiplier issue/completion controller:
// function encoding, operand sign decode and per-stage tag metadata.
package mult_pkg;

    typedef enum logic [1:0] {
        FUNC_MUL    = 2'd0,
        FUNC_MULH   = 2'd1,
        FUNC_MULHSU = 2'd2,
        FUNC_MULHU  = 2'd3
    } mult_func_t;

    // Metadata tag width; the controller's TAG_W is expected to match.
    localparam int META_TAG_W = 6;

    typedef struct packed {
        logic                  occ;
        logic                  live;
        logic                  hi;
        logic [META_TAG_W-1:0] tag;
    } meta_t;

    // bit0 = mcand (rs1) signed, bit1 = mplier (rs2) signed
    function automatic logic [1:0] sign_decode(input mult_func_t func);
        logic [1:0] sign;
        case (func)
            FUNC_MUL:    sign = 2'b00;
            FUNC_MULH:   sign = 2'b11;
            FUNC_MULHSU: sign = 2'b01;
            FUNC_MULHU:  sign = 2'b00;
            default:     sign = 2'b00;
        endcase
        return sign;
    endfunction

endpackage

// File: rtl/mult_issue_ctrl_chk.sv
// Runtime invariants for the multiplier issue controller: the attached
// multiplier's done must line up with tag metadata, and the FIFO never overflows.
module mult_issue_ctrl_chk (
    input logic clock,
    input logic reset_i,
    input logic mult_done_i,
    input logic last_occ_i,
    input logic push_i,
    input logic pop_i,
    input logic full_i
);

    a_done_tracks_occ: assert property (@(posedge clock) disable iff (reset_i)
        mult_done_i == last_occ_i);

    a_no_overflow: assert property (@(posedge clock) disable iff (reset_i)
        !(push_i && full_i && !pop_i));

endmodule

// File: rtl/mult_result_fifo.sv
// Synchronous result FIFO with wrap-around pointers, occupancy count and a
// synchronous clear that discards any same-cycle push or pop.
module mult_result_fifo #(
    parameter int DEPTH = 6,
    parameter int WIDTH = 38,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_s, full_s, do_push_s, do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
    endfunction

    // Handshake qualification and next pointer/count state
    always_comb begin
        empty_s   = (count_q == {CNT_W{1'b0}});
        full_s    = (count_q == CNT_W'(DEPTH));
        do_pop_s  = pop_i && !empty_s;
        do_push_s = push_i && (!full_s || do_pop_s);
        wr_ptr_d  = do_push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = do_pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clock) begin
        if (reset_i || clear_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clock) begin
        if (do_push_s && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Head is forced to zero while empty so idle CDB fields read as zero.
    assign head_data_o = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];
    assign empty_o     = empty_s;
    assign full_o      = full_s;
    assign count_o     = count_q;

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue/completion controller for the pipelined RV32M multiplier: decodes sign
// controls, carries tags beside the untagged pipeline and buffers results for the CDB.
module mult_issue_ctrl
    import mult_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_STAGE = 4,
    parameter int TAG_W     = 6,
    parameter int DEPTH     = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [1:0]        issue_func,
    input  logic [XLEN-1:0]   issue_rs1,
    input  logic [XLEN-1:0]   issue_rs2,
    input  logic [TAG_W-1:0]  issue_tag,
    output logic              mult_start,
    output logic [1:0]        mult_sign,
    output logic [XLEN-1:0]   mult_mcand,
    output logic [XLEN-1:0]   mult_mplier,
    input  logic [2*XLEN-1:0] mult_product,
    input  logic              mult_done,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [XLEN-1:0]   cdb_value,
    input  logic              cdb_grant
);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int CRD_W  = $clog2(DEPTH + NUM_STAGE + 1);
    localparam int DATA_W = TAG_W + XLEN;

    meta_t             meta_q [NUM_STAGE];
    meta_t             meta_d [NUM_STAGE];
    meta_t             last_s;
    logic [CRD_W-1:0]  inflight_s, credit_used_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fire_s, push_s, pop_s, fifo_empty_s, fifo_full_s;
    logic [DATA_W-1:0] push_data_s, head_data_s;

    // Dead (flushed) ops still hold a credit until they leave the pipeline.
    always_comb begin
        inflight_s = {CRD_W{1'b0}};
        for (int i = 0; i < NUM_STAGE; i++) begin
            inflight_s = inflight_s + CRD_W'(meta_q[i].occ);
        end
        credit_used_s = inflight_s + CRD_W'(fifo_count_s);
    end

    assign issue_ready = !reset && !flush && (credit_used_s < CRD_W'(DEPTH));
    assign fire_s      = issue_valid && issue_ready;
    assign mult_start  = fire_s;
    assign mult_sign   = sign_decode(mult_func_t'(issue_func));
    assign mult_mcand  = issue_rs1;
    assign mult_mplier = issue_rs2;

    // Metadata shift: load entry 0 on fire, shift the rest, kill live bits on flush
    always_comb begin
        meta_d[0].occ  = fire_s;
        meta_d[0].live = fire_s;
        meta_d[0].hi   = (issue_func != FUNC_MUL);
        meta_d[0].tag  = META_TAG_W'(issue_tag);
        for (int i = 1; i < NUM_STAGE; i++) begin
            meta_d[i] = meta_q[i-1];
        end
        for (int i = 0; i < NUM_STAGE; i++) begin
            meta_d[i].live = meta_d[i].live && !flush;
        end
    end

    // Metadata registers advance every cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                meta_q[i] <= '0;
            end
        end else begin
            meta_q <= meta_d;
        end
    end

    assign last_s      = meta_q[NUM_STAGE-1];
    assign push_s      = mult_done && last_s.live;
    assign pop_s       = cdb_valid && cdb_grant;
    assign push_data_s = {TAG_W'(last_s.tag),
                          last_s.hi ? mult_product[2*XLEN-1:XLEN] : mult_product[XLEN-1:0]};

    mult_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clock       (clock),
        .reset_i     (reset),
        .clear_i     (flush),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .head_data_o (head_data_s),
        .empty_o     (fifo_empty_s),
        .full_o      (fifo_full_s),
        .count_o     (fifo_count_s)
    );

    assign cdb_valid = !fifo_empty_s;
    assign cdb_tag   = head_data_s[DATA_W-1:XLEN];
    assign cdb_value = head_data_s[XLEN-1:0];

    mult_issue_ctrl_chk u_chk (
        .clock       (clock),
        .reset_i     (reset),
        .mult_done_i (mult_done),
        .last_occ_i  (last_s.occ),
        .push_i      (push_s),
        .pop_i       (pop_s),
        .full_i      (fifo_full_s)
    );

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Scoreboard bench for mult_issue_ctrl with a behavioural multiplier beside it.
module tb_mult_issue_ctrl;
    localparam int XLEN  = 32;
    localparam int NS    = 4;
    localparam int TW    = 6;
    localparam int DEPTH = 6;

    logic              clock = 1'b0;
    logic              reset, flush, issue_valid, issue_ready;
    logic [1:0]        issue_func;
    logic [XLEN-1:0]   issue_rs1, issue_rs2;
    logic [TW-1:0]     issue_tag;
    logic              mult_start;
    logic [1:0]        mult_sign;
    logic [XLEN-1:0]   mult_mcand, mult_mplier;
    logic [2*XLEN-1:0] mult_product;
    logic              mult_done;
    logic              cdb_valid, cdb_grant;
    logic [TW-1:0]     cdb_tag;
    logic [XLEN-1:0]   cdb_value;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mult_issue_ctrl #(.XLEN(XLEN), .NUM_STAGE(NS), .TAG_W(TW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_func(issue_func),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_tag(issue_tag),
        .mult_start(mult_start), .mult_sign(mult_sign),
        .mult_mcand(mult_mcand), .mult_mplier(mult_mplier),
        .mult_product(mult_product), .mult_done(mult_done),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_grant(cdb_grant)
    );

    // Attached multiplier: fixed NS-cycle latency, not flushable, cleared by reset.
    function automatic logic [63:0] mult_hw(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = s[0] ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s[1] ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    logic [NS-1:0] mv_q;
    logic [63:0]   mp_q [NS];
    always_ff @(posedge clock) begin
        if (reset) begin
            mv_q <= '0;
        end else begin
            mv_q     <= {mv_q[NS-2:0], mult_start};
            mp_q[0]  <= mult_hw(mult_sign, mult_mcand, mult_mplier);
            for (int i = 1; i < NS; i++) mp_q[i] <= mp_q[i-1];
        end
    end
    assign mult_done    = mv_q[NS-1];
    assign mult_product = mp_q[NS-1];

    // Architectural RV32M result straight from the function code.
    function automatic logic [31:0] rv32m(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] full;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            2'd0:    return a * b;
            2'd1:    full = 64'(sa * sb);
            2'd2:    full = 64'(sa * ub);
            default: full = 64'(ua * ub);
        endcase
        return full[63:32];
    endfunction

    function automatic logic [1:0] exp_sign(input logic [1:0] f);
        case (f)
            2'd1:    return 2'b11;
            2'd2:    return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h time=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct { logic [TW-1:0] tag; logic [31:0] val; int cyc; } exp_t;
    exp_t sb[$];
    int   fires[$];
    int   now        = 0;
    int   fire_total = 0;
    logic exp_ready  = 1'b0;
    logic prev_reset = 1'b1;

    // CDB monitor: credit/latency model, head comparison and pops
    always @(negedge clock) begin
        int infl, buf_n;
        now++;
        while (fires.size() > 0 && fires[0] < now - NS) void'(fires.pop_front());
        infl  = fires.size();
        buf_n = 0;
        foreach (sb[i]) if (sb[i].cyc + NS + 1 <= now) buf_n++;
        exp_ready = !reset && !flush && (infl + buf_n < DEPTH);
        check("issue_ready", 64'(issue_ready), 64'(exp_ready));
        check("cdb_valid", 64'(cdb_valid), 64'(buf_n > 0));
        if (cdb_valid && buf_n > 0) begin
            check("cdb_tag", 64'(cdb_tag), 64'(sb[0].tag));
            check("cdb_value", 64'(cdb_value), 64'(sb[0].val));
            if (cdb_grant && !flush && !reset) void'(sb.pop_front());
        end
        if (prev_reset && !reset) begin
            check("post_reset_tag", 64'(cdb_tag), 64'd0);
            check("post_reset_value", 64'(cdb_value), 64'd0);
        end
        if (flush) sb.delete();
        if (reset) begin
            sb.delete();
            fires.delete();
        end
        prev_reset = reset;
    end

    // Issue observer: records expected responses when an op is accepted
    always @(negedge clock) begin
        #2;
        if (issue_valid && exp_ready) begin
            check("mult_start", 64'(mult_start), 64'd1);
            check("mult_sign", 64'(mult_sign), 64'(exp_sign(issue_func)));
            check("mult_mcand", 64'(mult_mcand), 64'(issue_rs1));
            check("mult_mplier", 64'(mult_mplier), 64'(issue_rs2));
            sb.push_back('{issue_tag, rv32m(issue_func, issue_rs1, issue_rs2), now});
            fires.push_back(now);
            fire_total++;
        end else begin
            check("mult_start_idle", 64'(mult_start), 64'd0);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t);
        issue_valid = 1'b1;
        issue_func  = f;
        issue_rs1   = a;
        issue_rs2   = b;
        issue_tag   = t;
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_rand();
        drive(2'($urandom_range(0, 3)), rand_opnd(), rand_opnd(), TW'($urandom_range(0, 63)));
    endtask

    task automatic drain(input string name);
        int n;
        issue_valid = 1'b0;
        cdb_grant   = 1'b1;
        n = 0;
        while ((sb.size() > 0 || fires.size() > 0) && n < 200) begin
            tick();
            n++;
        end
        check(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int base;
        reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_func = 2'd0;
        issue_rs1 = 32'd0; issue_rs2 = 32'd0; issue_tag = '0; cdb_grant = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Single MULH: latency and value
        cdb_grant = 1'b1;
        drive(2'd1, 32'hFFFF_FFFE, 32'd3, 6'd5);
        tick();
        issue_valid = 1'b0;
        repeat (8) tick();

        // Back-to-back MUL / MULHU / MULHSU
        drive(2'd0, 32'h0001_0000, 32'h0001_0000, 6'd1); tick();
        drive(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd2); tick();
        drive(2'd2, 32'hFFFF_FFFF, 32'd2, 6'd3);         tick();
        issue_valid = 1'b0;
        repeat (8) tick();

        // Credit exhaustion with grant held low
        cdb_grant = 1'b0;
        base = fire_total;
        repeat (12) begin drive_rand(); tick(); end
        issue_valid = 1'b0;
        check("credit_fires", 64'(fire_total - base), 64'd6);
        drain("credit_drain");

        // Flush with one result buffered and three in flight
        cdb_grant = 1'b0;
        drive_rand(); tick();
        issue_valid = 1'b0;
        repeat (5) tick();
        repeat (3) begin drive_rand(); tick(); end
        issue_valid = 1'b0;
        tick();
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (3) tick();
        cdb_grant = 1'b1;
        repeat (6) tick();
        drain("flush_drain");

        // Randomized traffic with grant gaps
        repeat (300) begin
            if ($urandom_range(0, 3) != 0) drive_rand(); else issue_valid = 1'b0;
            cdb_grant = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 60) == 0);
            tick();
            flush = 1'b0;
        end
        drain("random_drain");

        // Reset with results buffered and in flight
        cdb_grant = 1'b0;
        repeat (2) begin drive_rand(); tick(); end
        issue_valid = 1'b0;
        repeat (5) tick();
        repeat (4) begin drive_rand(); tick(); end
        issue_valid = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        cdb_grant = 1'b1;
        repeat (10) tick();
        drain("reset_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_issue_ctrl.md
# mult_issue_ctrl

Issue/completion controller for the pipelined RV32M multiplier. It accepts multiply ops from the reservation station and decodes MUL/MULH/MULHSU/MULHU into operand sign controls. Tags travel alongside the untagged `mult` pipeline. Results are buffered in a small FIFO and presented to the CDB under a valid/grant handshake. A credit check guarantees the non-stallable multiplier never produces a result with nowhere to go.

## Interface
- XLEN, 32, operand/result width
- NUM_STAGE, 4, pipeline depth of the attached `mult`; must match its parameter
- TAG_W, 6, destination tag width
- DEPTH, 6, result FIFO entries; must be ≥1; NUM_STAGE+2 is required for 1 op/cycle sustained

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  squash all in-flight and buffered ops
- issue_valid  in  1  op offered
- issue_ready  out  1  op can be accepted
- issue_func  in  2  mult_func_t: MUL=0, MULH=1, MULHSU=2, MULHU=3
- issue_rs1, issue_rs2  in  XLEN  operands
- issue_tag  in  TAG_W  destination tag
- mult_start  out  1  to mult.start
- mult_sign  out  2  to mult.sign; bit0 applies to mcand, bit1 to mplier
- mult_mcand, mult_mplier  out  XLEN  rs1, rs2 pass-through
- mult_product  in  2*XLEN  from mult.product
- mult_done  in  1  from mult.done
- cdb_valid  out  1  FIFO head valid
- cdb_tag  out  TAG_W  head tag
- cdb_value  out  XLEN  head result
- cdb_grant  in  1  head consumed this cycle

## Operation
- Fire = issue_valid && issue_ready. mult_start = fire (combinational). mult_mcand = rs1, mult_mplier = rs2.
- Sign decode: MUL→00, MULH→11, MULHSU→01 (rs1 signed, rs2 unsigned), MULHU→00.
- Metadata shift register: NUM_STAGE entries of {occ, live, hi, tag}. It advances every cycle. Entry 0 is loaded with {fire, fire, func≠MUL, tag}.
  - Invariant (assert): mult_done == occ of the last entry.
- Completion: when mult_done && live, push {tag, hi ? product[2XLEN-1:XLEN] : product[XLEN-1:0]} into the FIFO. Dead entries are dropped.
- Credits: inflight = count of occ entries (dead ones included). issue_ready = !reset && !flush && (inflight + fifo_count < DEPTH). It is computed from registered state only; a same-cycle pop gives no credit.
- CDB: cdb_valid = FIFO non-empty. Pop on cdb_valid && cdb_grant. cdb_tag/cdb_value are stable while valid and not granted.
- Flush: FIFO is emptied at the clock edge; all live bits are cleared; occ bits are kept so credits stay conservative. Any pop or push in the flush cycle is discarded. There is no issue in the flush cycle.
- Push and pop in the same cycle are allowed; fifo_count is unchanged. FIFO overflow is impossible by credit; assert it.

## Timing
- Reset values: issue_ready 0 during reset, then 1 the cycle after. mult_start 0, cdb_valid 0, cdb_tag 0, cdb_value 0. FIFO pointers and count are 0; all metadata occ/live are 0.
- Latency: fire in cycle T → mult_done in T+NUM_STAGE → cdb_valid in T+NUM_STAGE+1 (earliest).
- Throughput: 1 op/cycle when DEPTH ≥ NUM_STAGE+2 and cdb_grant is held high.
- Reset mid-operation: all state cleared the next cycle. mult's done is also reset, so no stale push occurs.
- Ordering: results leave in issue order; there is no reordering.

## Structure
- Package `mult_pkg`: mult_func_t enum, the sign-decode function, and a meta_t struct {occ, live, hi, tag}.
- Sub-module `mult_result_fifo`: synchronous FIFO (DEPTH, width TAG_W+XLEN) with count output, push/pop/clear, and wrap-around pointers.
- The controller holds the metadata shift register, credit logic and decode. The `mult` instance sits beside it in the FU wrapper.

## Test plan
- MULH rs1=0xFFFFFFFE, rs2=3, tag 5 → cdb_valid at T+5; tag 5, value 0xFFFFFFFF; mult_sign=11 at fire.
- Back-to-back MUL 0x10000×0x10000 (→0x00000000), MULHU 0xFFFFFFFF×0xFFFFFFFF (→0xFFFFFFFE), MULHSU 0xFFFFFFFF×2 (→0xFFFFFFFF), grant held high → three results on consecutive cycles, in issue order, with correct tags.
- cdb_grant held low with continuous issue → exactly 6 fires, then issue_ready=0. Release grant → issue_ready returns the cycle after inflight+count drops below 6; all 6 results drain in order.
- Flush two cycles after 3 fires, with 1 result buffered → FIFO empty next cycle. No dead results ever appear on the CDB. Credits recover after NUM_STAGE cycles.
- Wrap-around: 20 ops with random grant gaps → the scoreboard matches every tag/value; no overflow assertion fires.
- Reset asserted with 4 in flight and 2 buffered → all outputs at reset values next cycle. No cdb_valid ever appears for pre-reset ops.
